// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline (A) writes over a 2-entry in-order FIFO of long-latency (B) results.
// Optional starvation guard compiled in with WB_STARVE_GUARD_EN; outputs are registered, one cycle after grant.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rw,
  input  logic [31:0] a_wd,
  input  logic        a_ovf,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rw,
  input  logic [31:0] b_wd,
  output logic [4:0]  rw,
  output logic [31:0] wd,
  output logic        RegWrite,
  output logic        overflow,
  output logic [31:0] pend_mask
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..7");
  end

  logic [4:0]  f_rw [2];
  logic [31:0] f_wd [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        fifo_ne, starve, a_grant, a_write, push, pop;

  assign fifo_ne = (count != 2'd0);

`ifdef WB_STARVE_GUARD_EN
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  logic [2:0] starve_cnt;

  assign starve = fifo_ne && (starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || !fifo_ne || pop) begin
      starve_cnt <= 3'd0;
    end else if (a_grant && starve_cnt != 3'd7) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  assign a_ready = ~rst & ~starve;
  assign b_ready = ~rst & (count != 2'd2);
  assign a_grant = a_valid & a_ready;
  assign a_write = a_grant & (a_rw != 5'd0);
  // The head issues whenever A is not producing a real write: idle, dropped (rw=0) or held off by the guard.
  assign pop     = ~rst & fifo_ne & ~a_write;
  assign push    = b_valid & b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      rw       <= 5'd0;
      wd       <= 32'd0;
      RegWrite <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        f_rw[wr_ptr] <= b_rw;
        f_wd[wr_ptr] <= b_wd;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};

      if (a_write) begin
        rw       <= a_rw;
        wd       <= a_wd;
        RegWrite <= 1'b1;
        overflow <= a_ovf;
      end else if (pop) begin
        rw       <= f_rw[rd_ptr];
        wd       <= f_wd[rd_ptr];
        RegWrite <= (f_rw[rd_ptr] != 5'd0);
        overflow <= 1'b0;
      end else begin
        RegWrite <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

  // Derived from registered FIFO state, so it follows each push/pop by one cycle.
  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (count == 2'd2 || (count == 2'd1 && rd_ptr == 1'(i))) begin
        pend_mask[f_rw[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; expectations follow the guard setting of the build.
module tb_wb_arbiter;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_ovf;
  logic [4:0]  a_rw, b_rw, rw;
  logic [31:0] a_wd, b_wd, wd, pend_mask;
  logic        b_valid, b_ready, RegWrite, overflow;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rw(a_rw), .a_wd(a_wd), .a_ovf(a_ovf),
    .b_valid(b_valid), .b_ready(b_ready), .b_rw(b_rw), .b_wd(b_wd),
    .rw(rw), .wd(wd), .RegWrite(RegWrite), .overflow(overflow), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        exp_rdy;
    logic        exp_b;
    logic [31:0] exp_wd;

    rst = 1'b1; a_valid = 1'b0; a_rw = '0; a_wd = '0; a_ovf = 1'b0;
    b_valid = 1'b0; b_rw = '0; b_wd = '0;
    step(); step();
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_pend", pend_mask, 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_b_ready", 32'(b_ready), 32'd1);

    // Case 1: plain A write, one-cycle latency
    a_valid = 1'b1; a_rw = 5'd5; a_wd = 32'h12345678; a_ovf = 1'b0;
    #1;
    check("c1_a_ready", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    check("c1_regwrite", 32'(RegWrite), 32'd1);
    check("c1_rw", 32'(rw), 32'd5);
    check("c1_wd", wd, 32'h12345678);
    check("c1_ovf", 32'(overflow), 32'd0);
    step();
    check("c1_idle_regwrite", 32'(RegWrite), 32'd0);

    // Overflow is passed through on an A grant
    a_valid = 1'b1; a_rw = 5'd6; a_wd = 32'h1; a_ovf = 1'b1;
    step();
    a_valid = 1'b0; a_ovf = 1'b0;
    check("ovf_regwrite", 32'(RegWrite), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    step();
    check("ovf_clear", 32'(overflow), 32'd0);

    // Case 2: fill FIFO with 7 then 9 while A keeps it from draining
    a_valid = 1'b1; a_rw = 5'd1; a_wd = 32'h11;
    b_valid = 1'b1; b_rw = 5'd7; b_wd = 32'hAA;
    #1;
    check("c2_b_ready0", 32'(b_ready), 32'd1);
    step();
    b_rw = 5'd9; b_wd = 32'hBB;
    step();
    b_valid = 1'b0; a_valid = 1'b0;
    check("c2_full_b_ready", 32'(b_ready), 32'd0);
    check("c2_full_pend", pend_mask, 32'h280);
    check("c2_a_write_rw", 32'(rw), 32'd1);
    step();
    check("c2_first_regwrite", 32'(RegWrite), 32'd1);
    check("c2_first_rw", 32'(rw), 32'd7);
    check("c2_first_wd", wd, 32'hAA);
    check("c2_mid_pend", pend_mask, 32'h200);
    check("c2_mid_b_ready", 32'(b_ready), 32'd1);
    step();
    check("c2_second_rw", 32'(rw), 32'd9);
    check("c2_second_wd", wd, 32'hBB);
    check("c2_second_regwrite", 32'(RegWrite), 32'd1);
    check("c2_empty_pend", pend_mask, 32'd0);
    step();
    check("c2_idle", 32'(RegWrite), 32'd0);

    // Case 3/4: one B entry waiting while A requests continuously
    a_valid = 1'b1; a_rw = 5'd2; a_wd = 32'h200;
    b_valid = 1'b1; b_rw = 5'd4; b_wd = 32'hC4;
    step();
    b_valid = 1'b0;
    check("c34_push_rw", 32'(rw), 32'd2);
    check("c34_pend", pend_mask, 32'h10);
    for (int i = 1; i <= 6; i++) begin
      a_wd = 32'h200 + 32'(i);
      exp_b = GUARD && (i == 5);
      exp_rdy = !exp_b;
      exp_wd = exp_b ? 32'hC4 : (32'h200 + 32'(i));
      #1;
      check($sformatf("c34_a_ready_%0d", i), 32'(a_ready), 32'(exp_rdy));
      step();
      check($sformatf("c34_rw_%0d", i), 32'(rw), exp_b ? 32'd4 : 32'd2);
      check($sformatf("c34_wd_%0d", i), wd, exp_wd);
    end
    check("c34_pend_after", pend_mask, GUARD ? 32'd0 : 32'h10);
    a_valid = 1'b0;
    step();
    check("c34_tail_regwrite", 32'(RegWrite), GUARD ? 32'd0 : 32'd1);
    check("c34_tail_rw", 32'(rw), GUARD ? 32'd2 : 32'd4);
    check("c34_tail_pend", pend_mask, 32'd0);

    // Case 5: dropped A (rw=0) lets FIFO head rw=3 issue the same cycle
    a_valid = 1'b1; a_rw = 5'd2; a_wd = 32'h300;
    b_valid = 1'b1; b_rw = 5'd3; b_wd = 32'h33;
    step();
    b_valid = 1'b0;
    a_rw = 5'd0; a_wd = 32'hDEAD; a_ovf = 1'b1;
    #1;
    check("c5_a_ready", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0; a_ovf = 1'b0;
    check("c5_regwrite", 32'(RegWrite), 32'd1);
    check("c5_rw", 32'(rw), 32'd3);
    check("c5_wd", wd, 32'h33);
    check("c5_ovf", 32'(overflow), 32'd0);
    check("c5_pend", pend_mask, 32'd0);

    // Dropped A with empty FIFO produces nothing
    a_valid = 1'b1; a_rw = 5'd0; a_wd = 32'hBEEF;
    step();
    a_valid = 1'b0;
    check("drop_regwrite", 32'(RegWrite), 32'd0);

    // B entry with rw=0 flows through but never writes
    b_valid = 1'b1; b_rw = 5'd0; b_wd = 32'h55;
    step();
    b_valid = 1'b0;
    check("b0_pend", pend_mask, 32'd0);
    step();
    check("b0_regwrite", 32'(RegWrite), 32'd0);

    // Case 6: reset with full FIFO and a pending A grant
    a_valid = 1'b1; a_rw = 5'd2; a_wd = 32'h600;
    b_valid = 1'b1; b_rw = 5'd10; b_wd = 32'hA0;
    step();
    b_rw = 5'd11; b_wd = 32'hB0;
    step();
    b_valid = 1'b0;
    check("c6_pend_full", pend_mask, 32'hC00);
    rst = 1'b1;
    #1;
    check("c6_rst_a_ready", 32'(a_ready), 32'd0);
    check("c6_rst_b_ready", 32'(b_ready), 32'd0);
    step();
    check("c6_regwrite", 32'(RegWrite), 32'd0);
    check("c6_pend", pend_mask, 32'd0);
    check("c6_b_ready_in_rst", 32'(b_ready), 32'd0);
    rst = 1'b0; a_valid = 1'b0;
    #1;
    check("c6_b_ready_after", 32'(b_ready), 32'd1);
    step();
    check("c6_no_stale1", 32'(RegWrite), 32'd0);
    step();
    check("c6_no_stale2", 32'(RegWrite), 32'd0);
    a_valid = 1'b1; a_rw = 5'd8; a_wd = 32'h800;
    step();
    a_valid = 1'b0;
    check("c6_first_grant", 32'(RegWrite), 32'd1);
    check("c6_first_rw", 32'(rw), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
